ram_burst_master: RTL and testbench

// - Initiator for the single-port RAM interface (clka/addra/ena/wea/dina/douta) of the DDR simulation memory.
// - Turns one command (base address, length, direction) into a burst of sequential single-word RAM accesses.
// - Read bursts: streams RAM data out over valid/ready, with a credit-controlled FIFO absorbing the 1-cycle RAM read latency.
// - Write bursts: accepts a valid/ready input stream and writes it to RAM.
// - Sits between the img2col / tensor loaders and the RAM model.

---
 rtl/ram_burst_master.sv | 257 +++++++++++++++++++++++++
 tb/tb_ram_burst_master.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_master.sv
`default_nettype none
// ============================================================================
// Module      : ram_burst_master
// Description : Turns one burst command (base address, length, direction)
//               into sequential single-word accesses on a single-port RAM.
//               Read data returns through a credit-controlled FIFO onto a
//               valid/ready stream; write data is taken from a valid/ready
//               stream and written to the RAM.
//               Optional build macro RAM_BURST_MASTER_PERF_EN adds the
//               saturating stall counters rd_stall_cnt / wr_stall_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_burst_master #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_SIZE  = 16,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clka,
    input  logic                  rst,
    // command
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [ADDR_SIZE-1:0]  cmd_addr,
    input  logic [LEN_W-1:0]      cmd_len,
    output logic                  done,
    // read-data stream
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    // write-data stream
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    // RAM port
    output logic [ADDR_SIZE-1:0]  addra,
    output logic                  ena,
    output logic                  wea,
    output logic [DATA_WIDTH-1:0] dina,
    input  logic [DATA_WIDTH-1:0] douta
`ifdef RAM_BURST_MASTER_PERF_EN
    ,
    output logic [31:0]           rd_stall_cnt,
    output logic [31:0]           wr_stall_cnt
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OUT_W = CNT_W + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [ADDR_SIZE-1:0]  r_addr;
    logic [LEN_W-1:0]      r_words_left;
    logic [LEN_W-1:0]      r_pop_left;
    logic                  r_rd_pend;   // read issued last cycle, ena high now
    logic                  r_inflight;  // RAM read data on douta this cycle

    logic [ADDR_SIZE-1:0]  r_addra;
    logic                  r_ena;
    logic                  r_wea;
    logic [DATA_WIDTH-1:0] r_dina;

    logic [DATA_WIDTH-1:0] r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    logic                  w_accept;
    logic                  w_issue;
    logic                  w_s_hs;
    logic                  w_push;
    logic                  w_pop;
    logic [OUT_W-1:0]      w_outstanding;

    // The RAM read pipeline is two stages deep (ena cycle, douta cycle), so
    // both stages are charged against FIFO space before a new read issues.
    assign w_outstanding = {1'b0, r_count} + OUT_W'(r_rd_pend) + OUT_W'(r_inflight);

    assign cmd_ready = (r_state == S_IDLE);
    assign w_accept  = cmd_ready && cmd_valid;
    assign w_issue   = (r_state == S_READ) && (r_words_left != '0) &&
                       (w_outstanding < OUT_W'(FIFO_DEPTH));
    assign s_ready   = (r_state == S_WRITE) && (r_words_left != '0);
    assign w_s_hs    = s_ready && s_valid;
    assign w_push    = r_inflight;
    assign m_valid   = (r_count != '0);
    assign w_pop     = m_valid && m_ready;
    assign m_data    = r_fifo[r_rd_ptr];
    assign m_last    = m_valid && (r_pop_left == LEN_W'(1));
    assign done      = (r_state == S_DONE);

    assign addra = r_addra;
    assign ena   = r_ena;
    assign wea   = r_wea;
    assign dina  = r_dina;

    // State register
    always_ff @(posedge clka) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; DRAIN leaves on the cycle the final word is popped
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (cmd_len == '0) begin
                        w_next = S_DONE;
                    end else if (cmd_wr) begin
                        w_next = S_WRITE;
                    end else begin
                        w_next = S_READ;
                    end
                end
            end
            S_READ: begin
                if (w_issue && (r_words_left == LEN_W'(1))) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pop && (r_pop_left == LEN_W'(1)) && !r_rd_pend && !r_inflight) begin
                    w_next = S_DONE;
                end
            end
            S_WRITE: begin
                if (w_s_hs && (r_words_left == LEN_W'(1))) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Burst bookkeeping and registered RAM port; ena/wea are single-cycle
    always_ff @(posedge clka) begin
        if (rst) begin
            r_addr       <= '0;
            r_words_left <= '0;
            r_pop_left   <= '0;
            r_rd_pend    <= 1'b0;
            r_inflight   <= 1'b0;
            r_addra      <= '0;
            r_ena        <= 1'b0;
            r_wea        <= 1'b0;
            r_dina       <= '0;
        end else begin
            r_ena      <= 1'b0;
            r_wea      <= 1'b0;
            r_rd_pend  <= w_issue;
            r_inflight <= r_rd_pend;

            if (w_accept) begin
                r_addr       <= cmd_addr;
                r_words_left <= cmd_len;
                r_pop_left   <= cmd_wr ? '0 : cmd_len;
            end

            if (w_issue) begin
                r_ena        <= 1'b1;
                r_addra      <= r_addr;
                r_addr       <= r_addr + ADDR_SIZE'(1);
                r_words_left <= r_words_left - LEN_W'(1);
            end

            if (w_s_hs) begin
                r_ena        <= 1'b1;
                r_wea        <= 1'b1;
                r_addra      <= r_addr;
                r_dina       <= s_data;
                r_addr       <= r_addr + ADDR_SIZE'(1);
                r_words_left <= r_words_left - LEN_W'(1);
            end

            if (w_pop) begin
                r_pop_left <= r_pop_left - LEN_W'(1);
            end
        end
    end

    // Read-return FIFO control: pointers and occupancy
    always_ff @(posedge clka) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Read-return FIFO storage; contents are don't-care while empty
    always_ff @(posedge clka) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= douta;
        end
    end

`ifdef RAM_BURST_MASTER_PERF_EN
    logic [31:0] r_rd_stall;
    logic [31:0] r_wr_stall;

    assign rd_stall_cnt = r_rd_stall;
    assign wr_stall_cnt = r_wr_stall;

    // Saturating stall counters: credit-blocked reads, starved writes
    always_ff @(posedge clka) begin
        if (rst) begin
            r_rd_stall <= '0;
            r_wr_stall <= '0;
        end else begin
            if ((r_state == S_READ) && (r_words_left != '0) && !w_issue &&
                (r_rd_stall != '1)) begin
                r_rd_stall <= r_rd_stall + 32'd1;
            end
            if (s_ready && !s_valid && (r_wr_stall != '1)) begin
                r_wr_stall <= r_wr_stall + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_burst_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ram_burst_master
// Description : Directed, table-driven bench for ram_burst_master with a
//               behavioural single-port RAM (unwritten words read as their
//               own address).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_burst_master;

    localparam int DW = 64;
    localparam int AW = 16;
    localparam int LW = 16;
    localparam int FD = 4;

    logic          clka = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_wr;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          done;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic [AW-1:0] addra;
    logic          ena;
    logic          wea;
    logic [DW-1:0] dina;
    logic [DW-1:0] douta = '0;
`ifdef RAM_BURST_MASTER_PERF_EN
    logic [31:0]   rd_stall_cnt;
    logic [31:0]   wr_stall_cnt;
`endif

    always #5 clka = ~clka;

    ram_burst_master #(
        .DATA_WIDTH (DW),
        .ADDR_SIZE  (AW),
        .LEN_W      (LW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clka      (clka),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .done      (done),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .addra     (addra),
        .ena       (ena),
        .wea       (wea),
        .dina      (dina),
        .douta     (douta)
`ifdef RAM_BURST_MASTER_PERF_EN
        ,
        .rd_stall_cnt (rd_stall_cnt),
        .wr_stall_cnt (wr_stall_cnt)
`endif
    );

    // RAM model: 1-cycle read latency; unwritten words read back as address
    bit [DW-1:0] wmem   [65536];
    bit          wvalid [65536];
    int          cyc     = 0;
    int          ena_cnt = 0;
    int          bad_wea = 0;

    always @(posedge clka) begin
        cyc     <= cyc + 1;
        ena_cnt <= ena_cnt + (ena ? 1 : 0);
        bad_wea <= bad_wea + ((wea && !ena) ? 1 : 0);
        if (ena) begin
            if (wea) begin
                wmem[addra]   <= dina;
                wvalid[addra] <= 1'b1;
            end else begin
                douta <= wvalid[addra] ? wmem[addra] : DW'(addra);
            end
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One burst record: stim fields plus hand-computed expectations.
    // base: first expected read word / first write data word.
    // hold: m_ready/s_valid stay low until (cycle - accept) > hold.
    // exp_stall_ena: ena pulses seen by (accept + hold), -1 = unchecked.
    // exp_stall: rd/wr stall counter increment, -1 = unchecked.
    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        int            hold;
        logic [DW-1:0] base;
        int            exp_stall_ena;
        int            exp_stall;
    } vec_t;

    task automatic run_vec(input vec_t v, input int idx);
        int            acc;
        int            k;
        int            t;
        int            first_v;
        int            last_c;
        int            done_c;
        int            e0;
        bit            got_done;
        logic [AW-1:0] ea;
        logic [DW-1:0] exp_d;
        logic [31:0]   st0;
        string         tag;
        tag      = $sformatf("v%0d", idx);
        k        = 0;
        t        = 0;
        first_v  = -1;
        last_c   = -1;
        done_c   = -1;
        got_done = 1'b0;
        @(negedge clka);
        check({tag, "_cmd_ready_idle"}, 64'(cmd_ready), 64'd1);
`ifdef RAM_BURST_MASTER_PERF_EN
        st0 = v.wr ? wr_stall_cnt : rd_stall_cnt;
`else
        st0 = '0;
`endif
        e0        = ena_cnt;
        cmd_valid = 1'b1;
        cmd_wr    = v.wr;
        cmd_addr  = v.addr;
        cmd_len   = v.len;
        acc       = cyc;
        @(negedge clka);
        cmd_valid = 1'b0;
        while (!got_done && t < 300) begin
            m_ready = !v.wr && ((cyc - acc) > v.hold);
            s_valid = v.wr && (k < int'(v.len)) && ((cyc - acc) > v.hold);
            s_data  = v.base + DW'(k);
            if (v.exp_stall_ena >= 0 && (cyc - acc) == v.hold) begin
                check({tag, "_ena_during_hold"}, 64'(ena_cnt - e0), 64'(v.exp_stall_ena));
                if (!v.wr && m_valid) begin
                    ea    = v.base[AW-1:0];
                    exp_d = DW'(ea);
                    check({tag, "_m_data_held"}, m_data, exp_d);
                end
            end
            if (done) begin
                got_done = 1'b1;
                done_c   = cyc;
            end else if (!v.wr && m_valid && m_ready) begin
                if (first_v < 0) first_v = cyc - acc;
                ea    = v.base[AW-1:0] + AW'(k);
                exp_d = DW'(ea);
                check($sformatf("%s_rd_data%0d", tag, k), m_data, exp_d);
                check($sformatf("%s_m_last%0d", tag, k), 64'(m_last),
                      64'(k == int'(v.len) - 1));
                k++;
                last_c = cyc;
            end else if (v.wr && s_valid && s_ready) begin
                k++;
                last_c = cyc;
            end
            if (!got_done) @(negedge clka);
            t++;
        end
        m_ready = 1'b0;
        s_valid = 1'b0;
        check({tag, "_done_seen"}, 64'(got_done), 64'd1);
        check({tag, "_word_count"}, 64'(k), 64'(v.len));
        if (v.len == '0) begin
            check({tag, "_done_latency_len0"}, 64'(done_c - acc), 64'd1);
        end else begin
            check({tag, "_done_after_last"}, 64'(done_c - last_c), 64'd1);
        end
        if (!v.wr && v.hold == 0 && v.len != '0) begin
            check({tag, "_first_valid_latency"}, 64'(first_v), 64'd4);
        end
        @(negedge clka);
        check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
        check({tag, "_cmd_ready_back"}, 64'(cmd_ready), 64'd1);
        @(negedge clka);
        check({tag, "_ena_total"}, 64'(ena_cnt - e0), 64'(v.len));
        if (v.wr) begin
            for (int j = 0; j < int'(v.len); j++) begin
                ea = v.addr + AW'(j);
                check($sformatf("%s_mem%0h", tag, ea), wmem[ea], v.base + DW'(j));
            end
        end
`ifdef RAM_BURST_MASTER_PERF_EN
        if (v.exp_stall >= 0) begin
            check({tag, "_stall_cnt"}, 64'((v.wr ? wr_stall_cnt : rd_stall_cnt) - st0),
                  64'(v.exp_stall));
        end
`else
        if (st0 != '0) n_err++;
`endif
    endtask

    vec_t vt [8];
    int   acc_r;

    initial begin
        // read bursts first (memory still holds mem[i] = i), then writes
        vt[0] = '{1'b0, 16'h0010, 16'd4, 0,  64'h10,   -1, -1};
        vt[1] = '{1'b0, 16'h0020, 16'd8, 20, 64'h20,    4, 17};
        vt[2] = '{1'b0, 16'hFFFE, 16'd3, 0,  64'hFFFE, -1, -1};
        vt[3] = '{1'b0, 16'h0005, 16'd1, 3,  64'h5,     1, -1};
        vt[4] = '{1'b1, 16'hFFFF, 16'd3, 0,  64'hAAAA_0000_0000_000A, -1, -1};
        vt[5] = '{1'b1, 16'h0100, 16'd5, 5,  64'h1234_5678_0000_0000, -1, 5};
        vt[6] = '{1'b0, 16'h0030, 16'd0, 0,  64'h0,    -1, -1};
        vt[7] = '{1'b1, 16'h0040, 16'd0, 0,  64'h0,    -1, -1};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        m_ready   = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        repeat (3) @(negedge clka);
        rst = 1'b0;

        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_m_valid",   64'(m_valid),   64'd0);
        check("rst_s_ready",   64'(s_ready),   64'd0);
        check("rst_done",      64'(done),      64'd0);
        check("rst_ena",       64'(ena),       64'd0);
        check("rst_wea",       64'(wea),       64'd0);
        check("rst_addra",     64'(addra),     64'd0);
        check("rst_dina",      dina,           64'd0);

        for (int i = 0; i < 8; i++) begin
            run_vec(vt[i], i);
        end

        // reset in the middle of a read burst with two words buffered
        @(negedge clka);
        cmd_valid = 1'b1;
        cmd_wr    = 1'b0;
        cmd_addr  = 16'h0040;
        cmd_len   = 16'd8;
        acc_r     = cyc;
        @(negedge clka);
        cmd_valid = 1'b0;
        m_ready   = 1'b0;
        while ((cyc - acc_r) < 5) @(negedge clka);
        check("midrst_m_valid_before", 64'(m_valid), 64'd1);
        rst = 1'b1;
        @(negedge clka);
        rst = 1'b0;
        check("midrst_m_valid", 64'(m_valid),   64'd0);
        check("midrst_ena",     64'(ena),       64'd0);
        check("midrst_cmd_rdy", 64'(cmd_ready), 64'd1);
        check("midrst_done",    64'(done),      64'd0);
        run_vec(vt[0], 8);

        check("wea_without_ena", 64'(bad_wea), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
